// File: rtl/tcm_arb_pkg.sv
// rtl/tcm_arb_pkg.sv - shared types and widths for the TCM data-port arbiter
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef SIZE_WIDTH
`define SIZE_WIDTH 3
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif

package tcm_arb_pkg;

    localparam int STARVE_CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_LSU  = 2'd1,
        OWNER_DBG  = 2'd2
    } rsp_owner_t;

endpackage

// File: rtl/tcm_port_arb2.sv
// rtl/tcm_port_arb2.sv - two-requester fixed-priority arbiter with debug starvation override
module tcm_port_arb2
    import tcm_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req_pri,
    input  logic i_req_dbg,
    output logic o_gnt_pri,
    output logic o_gnt_dbg
);

    localparam logic [STARVE_CNT_WIDTH-1:0] LP_LIMIT = STARVE_CNT_WIDTH'(STARVE_LIMIT);
    localparam logic [STARVE_CNT_WIDTH-1:0] LP_ONE   = STARVE_CNT_WIDTH'(1);

    logic [STARVE_CNT_WIDTH-1:0] r_starve_cnt;
    logic                        w_override;

    // Debug jumps the queue for exactly one grant once it has been refused LIMIT times in a row.
    assign w_override = (r_starve_cnt == LP_LIMIT);
    assign o_gnt_dbg  = i_req_dbg & (~i_req_pri | w_override);
    assign o_gnt_pri  = i_req_pri & ~o_gnt_dbg;

    // Count consecutive refused debug cycles; clear on a debug grant or when debug is not asking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (!i_req_dbg || o_gnt_dbg) begin
            r_starve_cnt <= '0;
        end else if (!w_override) begin
            r_starve_cnt <= r_starve_cnt + LP_ONE;
        end
    end

endmodule

// File: rtl/tcm_data_port_arbiter.sv
// rtl/tcm_data_port_arbiter.sv - shares the TCM stbuf read/write ports between LSU, store buffer and debug
module tcm_data_port_arbiter
    import tcm_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        lsu_rd_valid,
    input  logic [`ADDR_WIDTH-1:0]      lsu_rd_addr,
    input  logic [`SIZE_WIDTH-1:0]      lsu_rd_size,
    output logic                        lsu_rd_ready,
    output logic                        lsu_rdata_valid,
    output logic [`BUS_DATA_WIDTH-1:0]  lsu_rdata,
    input  logic                        stbuf_wr_valid,
    input  logic [`ADDR_WIDTH-1:0]      stbuf_wr_addr,
    input  logic [`SIZE_WIDTH-1:0]      stbuf_wr_size,
    input  logic [`REG_DATA_WIDTH-1:0]  stbuf_wr_data,
    output logic                        stbuf_wr_ready,
    input  logic                        dbg_valid,
    input  logic                        dbg_we,
    input  logic [`ADDR_WIDTH-1:0]      dbg_addr,
    input  logic [`SIZE_WIDTH-1:0]      dbg_size,
    input  logic [`REG_DATA_WIDTH-1:0]  dbg_wdata,
    output logic                        dbg_ready,
    output logic                        dbg_rdata_valid,
    output logic [`BUS_DATA_WIDTH-1:0]  dbg_rdata,
    output logic [`ADDR_WIDTH-1:0]      bus_tcm_stbuf_read_addr,
    output logic [`SIZE_WIDTH-1:0]      bus_tcm_stbuf_read_size,
    output logic                        bus_tcm_stbuf_rd,
    output logic [`ADDR_WIDTH-1:0]      bus_tcm_stbuf_write_addr,
    output logic [`SIZE_WIDTH-1:0]      bus_tcm_stbuf_write_size,
    output logic [`REG_DATA_WIDTH-1:0]  bus_tcm_stbuf_data,
    output logic                        bus_tcm_stbuf_wr,
    input  logic [`BUS_DATA_WIDTH-1:0]  tcm_bus_stbuf_data
);

    logic       w_rd_req_lsu;
    logic       w_rd_req_dbg;
    logic       w_wr_req_sb;
    logic       w_wr_req_dbg;
    logic       w_rd_gnt_lsu;
    logic       w_rd_gnt_dbg;
    logic       w_wr_gnt_sb;
    logic       w_wr_gnt_dbg;
    rsp_owner_t r_rsp_owner;

    // Requests are masked during reset so no ready or strobe can leak out.
    assign w_rd_req_lsu = lsu_rd_valid & ~rst;
    assign w_rd_req_dbg = dbg_valid & ~dbg_we & ~rst;
    assign w_wr_req_sb  = stbuf_wr_valid & ~rst;
    assign w_wr_req_dbg = dbg_valid & dbg_we & ~rst;

    tcm_port_arb2 #(.STARVE_LIMIT(STARVE_LIMIT)) u_rd_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req_pri (w_rd_req_lsu),
        .i_req_dbg (w_rd_req_dbg),
        .o_gnt_pri (w_rd_gnt_lsu),
        .o_gnt_dbg (w_rd_gnt_dbg)
    );

    tcm_port_arb2 #(.STARVE_LIMIT(STARVE_LIMIT)) u_wr_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req_pri (w_wr_req_sb),
        .i_req_dbg (w_wr_req_dbg),
        .o_gnt_pri (w_wr_gnt_sb),
        .o_gnt_dbg (w_wr_gnt_dbg)
    );

    assign lsu_rd_ready     = w_rd_gnt_lsu;
    assign stbuf_wr_ready   = w_wr_gnt_sb;
    assign dbg_ready        = w_rd_gnt_dbg | w_wr_gnt_dbg;
    assign bus_tcm_stbuf_rd = w_rd_gnt_lsu | w_rd_gnt_dbg;
    assign bus_tcm_stbuf_wr = w_wr_gnt_sb | w_wr_gnt_dbg;

    // Read-port address/size follow the read winner (LSU values when idle).
    always_comb begin
        bus_tcm_stbuf_read_addr = lsu_rd_addr;
        bus_tcm_stbuf_read_size = lsu_rd_size;
        if (w_rd_gnt_dbg) begin
            bus_tcm_stbuf_read_addr = dbg_addr;
            bus_tcm_stbuf_read_size = dbg_size;
        end
    end

    // Write-port address/size/data follow the write winner (store-buffer values when idle).
    always_comb begin
        bus_tcm_stbuf_write_addr = stbuf_wr_addr;
        bus_tcm_stbuf_write_size = stbuf_wr_size;
        bus_tcm_stbuf_data       = stbuf_wr_data;
        if (w_wr_gnt_dbg) begin
            bus_tcm_stbuf_write_addr = dbg_addr;
            bus_tcm_stbuf_write_size = dbg_size;
            bus_tcm_stbuf_data       = dbg_wdata;
        end
    end

    // Remember who issued this cycle's read so next cycle's TCM data goes back to them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_owner <= OWNER_NONE;
        end else if (w_rd_gnt_dbg) begin
            r_rsp_owner <= OWNER_DBG;
        end else if (w_rd_gnt_lsu) begin
            r_rsp_owner <= OWNER_LSU;
        end else begin
            r_rsp_owner <= OWNER_NONE;
        end
    end

    assign lsu_rdata_valid = (r_rsp_owner == OWNER_LSU);
    assign dbg_rdata_valid = (r_rsp_owner == OWNER_DBG);
    assign lsu_rdata       = tcm_bus_stbuf_data;
    assign dbg_rdata       = tcm_bus_stbuf_data;

endmodule

// File: tb/tb_tcm_data_port_arbiter.sv
// tb/tb_tcm_data_port_arbiter.sv - self-checking bench for tcm_data_port_arbiter
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef SIZE_WIDTH
`define SIZE_WIDTH 3
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif

module tb_tcm_data_port_arbiter;

    localparam int LIMIT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       rst;
    logic                       lsu_rd_valid;
    logic [`ADDR_WIDTH-1:0]     lsu_rd_addr;
    logic [`SIZE_WIDTH-1:0]     lsu_rd_size;
    logic                       lsu_rd_ready;
    logic                       lsu_rdata_valid;
    logic [`BUS_DATA_WIDTH-1:0] lsu_rdata;
    logic                       stbuf_wr_valid;
    logic [`ADDR_WIDTH-1:0]     stbuf_wr_addr;
    logic [`SIZE_WIDTH-1:0]     stbuf_wr_size;
    logic [`REG_DATA_WIDTH-1:0] stbuf_wr_data;
    logic                       stbuf_wr_ready;
    logic                       dbg_valid;
    logic                       dbg_we;
    logic [`ADDR_WIDTH-1:0]     dbg_addr;
    logic [`SIZE_WIDTH-1:0]     dbg_size;
    logic [`REG_DATA_WIDTH-1:0] dbg_wdata;
    logic                       dbg_ready;
    logic                       dbg_rdata_valid;
    logic [`BUS_DATA_WIDTH-1:0] dbg_rdata;
    logic [`ADDR_WIDTH-1:0]     rd_addr;
    logic [`SIZE_WIDTH-1:0]     rd_size;
    logic                       rd;
    logic [`ADDR_WIDTH-1:0]     wr_addr;
    logic [`SIZE_WIDTH-1:0]     wr_size;
    logic [`REG_DATA_WIDTH-1:0] wr_data;
    logic                       wr;
    logic [`BUS_DATA_WIDTH-1:0] tcm_data;

    tcm_data_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .lsu_rd_valid             (lsu_rd_valid),
        .lsu_rd_addr              (lsu_rd_addr),
        .lsu_rd_size              (lsu_rd_size),
        .lsu_rd_ready             (lsu_rd_ready),
        .lsu_rdata_valid          (lsu_rdata_valid),
        .lsu_rdata                (lsu_rdata),
        .stbuf_wr_valid           (stbuf_wr_valid),
        .stbuf_wr_addr            (stbuf_wr_addr),
        .stbuf_wr_size            (stbuf_wr_size),
        .stbuf_wr_data            (stbuf_wr_data),
        .stbuf_wr_ready           (stbuf_wr_ready),
        .dbg_valid                (dbg_valid),
        .dbg_we                   (dbg_we),
        .dbg_addr                 (dbg_addr),
        .dbg_size                 (dbg_size),
        .dbg_wdata                (dbg_wdata),
        .dbg_ready                (dbg_ready),
        .dbg_rdata_valid          (dbg_rdata_valid),
        .dbg_rdata                (dbg_rdata),
        .bus_tcm_stbuf_read_addr  (rd_addr),
        .bus_tcm_stbuf_read_size  (rd_size),
        .bus_tcm_stbuf_rd         (rd),
        .bus_tcm_stbuf_write_addr (wr_addr),
        .bus_tcm_stbuf_write_size (wr_size),
        .bus_tcm_stbuf_data       (wr_data),
        .bus_tcm_stbuf_wr         (wr),
        .tcm_bus_stbuf_data       (tcm_data)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: refusal counts per port and the owner of the read in flight.
    int m_rd_refused = 0;
    int m_wr_refused = 0;
    int m_owner      = 0;   // 0 none, 1 lsu, 2 dbg
    bit e_lsu, e_sb, e_dbgr, e_dbgw;

    typedef struct {
        bit       lsu;
        bit       sb;
        bit       dv;
        bit       dwe;
        bit [2:0] exp_rdy;   // {lsu_rd_ready, stbuf_wr_ready, dbg_ready}
        bit [1:0] exp_rdwr;  // {rd, wr}
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic void model_grants();
        bit rd_dreq, wr_dreq;
        rd_dreq = dbg_valid && !dbg_we;
        wr_dreq = dbg_valid && dbg_we;
        e_dbgr  = !rst && rd_dreq && (!lsu_rd_valid || m_rd_refused == LIMIT);
        e_lsu   = !rst && lsu_rd_valid && !e_dbgr;
        e_dbgw  = !rst && wr_dreq && (!stbuf_wr_valid || m_wr_refused == LIMIT);
        e_sb    = !rst && stbuf_wr_valid && !e_dbgw;
    endfunction

    task automatic check_now();
        @(negedge clk);
        model_grants();
        chk("ready", {lsu_rd_ready, stbuf_wr_ready, dbg_ready}, {e_lsu, e_sb, e_dbgr | e_dbgw});
        chk("rd_wr", {rd, wr}, {(e_lsu | e_dbgr), (e_sb | e_dbgw)});
        if (e_lsu)  chk("rd_mux_lsu", {rd_addr, rd_size}, {lsu_rd_addr, lsu_rd_size});
        if (e_dbgr) chk("rd_mux_dbg", {rd_addr, rd_size}, {dbg_addr, dbg_size});
        if (e_sb)   chk("wr_mux_sb", {wr_addr, wr_size, wr_data}, {stbuf_wr_addr, stbuf_wr_size, stbuf_wr_data});
        if (e_dbgw) chk("wr_mux_dbg", {wr_addr, wr_size, wr_data}, {dbg_addr, dbg_size, dbg_wdata});
        chk("rvalid", {lsu_rdata_valid, dbg_rdata_valid}, {m_owner == 1, m_owner == 2});
        if (m_owner == 1) chk("lsu_rdata", lsu_rdata, tcm_data);
        if (m_owner == 2) chk("dbg_rdata", dbg_rdata, tcm_data);
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            m_rd_refused = 0;
            m_wr_refused = 0;
            m_owner      = 0;
        end else begin
            m_owner = e_dbgr ? 2 : (e_lsu ? 1 : 0);
            if (!(dbg_valid && !dbg_we) || e_dbgr) m_rd_refused = 0;
            else if (m_rd_refused < LIMIT) m_rd_refused++;
            if (!(dbg_valid && dbg_we) || e_dbgw) m_wr_refused = 0;
            else if (m_wr_refused < LIMIT) m_wr_refused++;
        end
        #1;
        tcm_data = $urandom;
    endtask

    task automatic cycle();
        check_now();
        advance();
    endtask

    task automatic idle_inputs();
        lsu_rd_valid   = 0;
        stbuf_wr_valid = 0;
        dbg_valid      = 0;
        dbg_we         = 0;
    endtask

    task automatic rand_payload();
        lsu_rd_addr   = $urandom;
        lsu_rd_size   = 3'(1 << $urandom_range(0, 2));
        stbuf_wr_addr = $urandom;
        stbuf_wr_size = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'(1 << $urandom_range(0, 2));
        stbuf_wr_data = $urandom;
        dbg_addr      = $urandom;
        dbg_size      = 3'(1 << $urandom_range(0, 2));
        dbg_wdata     = $urandom;
    endtask

    initial begin
        vecs[0] = '{0, 0, 0, 0, 3'b000, 2'b00};
        vecs[1] = '{1, 0, 0, 0, 3'b100, 2'b10};
        vecs[2] = '{0, 1, 0, 0, 3'b010, 2'b01};
        vecs[3] = '{0, 0, 1, 0, 3'b001, 2'b10};
        vecs[4] = '{0, 0, 1, 1, 3'b001, 2'b01};
        vecs[5] = '{1, 0, 1, 0, 3'b100, 2'b10};
        vecs[6] = '{0, 1, 1, 1, 3'b010, 2'b01};
        vecs[7] = '{1, 0, 1, 1, 3'b101, 2'b11};
        vecs[8] = '{0, 1, 1, 0, 3'b011, 2'b11};
        vecs[9] = '{1, 1, 1, 0, 3'b110, 2'b11};

        rst = 1;
        tcm_data = '0;
        rand_payload();
        lsu_rd_valid = 1; stbuf_wr_valid = 1; dbg_valid = 1; dbg_we = 0;
        check_now();
        chk("reset_outputs", {lsu_rd_ready, stbuf_wr_ready, dbg_ready, rd, wr, lsu_rdata_valid, dbg_rdata_valid}, 7'b0);
        advance();
        advance();
        rst = 0;
        idle_inputs();
        cycle();

        // Single-cycle vectors, each followed by an idle cycle that clears the starvation counts.
        for (int i = 0; i < 10; i++) begin
            rand_payload();
            lsu_rd_valid = vecs[i].lsu; stbuf_wr_valid = vecs[i].sb;
            dbg_valid = vecs[i].dv;     dbg_we = vecs[i].dwe;
            check_now();
            chk($sformatf("vec%0d_ready", i), {lsu_rd_ready, stbuf_wr_ready, dbg_ready}, vecs[i].exp_rdy);
            chk($sformatf("vec%0d_rdwr", i), {rd, wr}, vecs[i].exp_rdwr);
            advance();
            idle_inputs();
            cycle();
        end

        // Plain LSU read returns TCM data one cycle later.
        lsu_rd_valid = 1; lsu_rd_addr = 32'h100; lsu_rd_size = 3'd4;
        check_now();
        chk("t1_grant", {lsu_rd_ready, rd, rd_addr}, {1'b1, 1'b1, 32'h100});
        advance();
        idle_inputs();
        tcm_data = 32'hDEADBEEF;
        check_now();
        chk("t1_resp", {lsu_rdata_valid, dbg_rdata_valid, lsu_rdata}, {1'b1, 1'b0, 32'hDEADBEEF});
        advance();

        // Debug read starved by continuous LSU reads gets one forced grant after LIMIT refusals.
        lsu_rd_valid = 1; dbg_valid = 1; dbg_we = 0;
        for (int i = 0; i < LIMIT; i++) begin
            check_now();
            chk($sformatf("t2_refused%0d", i), {dbg_ready, lsu_rd_ready}, 2'b01);
            advance();
        end
        check_now();
        chk("t2_forced", {dbg_ready, lsu_rd_ready, rd_addr}, {1'b1, 1'b0, dbg_addr});
        advance();
        check_now();
        chk("t2_resp", {dbg_rdata_valid, lsu_rdata_valid, dbg_ready}, 3'b100);
        advance();
        idle_inputs();
        cycle();

        // Read and write issue together in one cycle.
        lsu_rd_valid = 1; lsu_rd_addr = 32'h200;
        stbuf_wr_valid = 1; stbuf_wr_addr = 32'h300; stbuf_wr_data = 32'h55; stbuf_wr_size = 3'd1;
        check_now();
        chk("t3_both", {rd, wr, lsu_rd_ready, stbuf_wr_ready, wr_addr, wr_data}, {4'b1111, 32'h300, 32'h55});
        advance();
        idle_inputs();

        // Store buffer beats debug write, debug goes next when store buffer idles.
        stbuf_wr_valid = 1; stbuf_wr_addr = 32'h400; dbg_valid = 1; dbg_we = 1; dbg_addr = 32'h480;
        check_now();
        chk("t4_sb_first", {stbuf_wr_ready, dbg_ready, wr_addr}, {2'b10, 32'h400});
        advance();
        stbuf_wr_valid = 0;
        check_now();
        chk("t4_dbg_next", {stbuf_wr_ready, dbg_ready, wr_addr}, {2'b01, 32'h480});
        advance();
        idle_inputs();
        cycle();

        // Back-to-back reads from different owners route to the right requester.
        lsu_rd_valid = 1;
        cycle();
        lsu_rd_valid = 0; dbg_valid = 1; dbg_we = 0;
        check_now();
        chk("t5_lsu_resp", {lsu_rdata_valid, dbg_rdata_valid}, 2'b10);
        advance();
        idle_inputs();
        check_now();
        chk("t5_dbg_resp", {lsu_rdata_valid, dbg_rdata_valid}, 2'b01);
        advance();

        // Reset mid-cycle after a read grant kills the response.
        lsu_rd_valid = 1;
        check_now();
        chk("t6_grant", lsu_rd_ready, 1'b1);
        #1 rst = 1;
        #1 chk("t6_ready_in_reset", {lsu_rd_ready, stbuf_wr_ready, dbg_ready, rd, wr}, 5'b0);
        advance();
        lsu_rd_valid = 0;
        check_now();
        chk("t6_no_resp", {lsu_rdata_valid, dbg_rdata_valid}, 2'b00);
        advance();
        rst = 0;
        cycle();

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rand_payload();
            lsu_rd_valid   = ($urandom_range(0, 3) != 0);
            stbuf_wr_valid = ($urandom_range(0, 3) != 0);
            dbg_valid      = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) dbg_we = ~dbg_we;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
